// File: rtl/tetris_input_pkg.sv
// Shared definitions for the Tetris button front end.
//   - Button indices used for every 4-bit button vector (bit 0 = Spin ... bit 3 = Down).
//   - Arbiter FSM state encoding.
//   - REPEATABLE: buttons that auto-repeat while held.
//   - grant_onehot(): fixed-priority pick, lowest index wins (Spin > Left > Right > Down).
package tetris_input_pkg;

  localparam int NUM_BTN   = 4;
  localparam int BTN_SPIN  = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_DOWN  = 3;

  localparam logic [NUM_BTN-1:0] REPEATABLE = 4'b1110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // Isolate the lowest set bit; index order is the grant priority.
  function automatic logic [NUM_BTN-1:0] grant_onehot(input logic [NUM_BTN-1:0] req);
    return req & (~req + 4'd1);
  endfunction

endpackage

// File: rtl/tetris_debounce.sv
// One button: 2-FF synchroniser, debounce counter and single-cycle edge pulses.
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   btn_raw    raw button, asynchronous to clk
//   rise       one-cycle pulse in the cycle after the debounced level goes high
//   fall       one-cycle pulse in the cycle after the debounced level goes low
// The debounced level flips once the synced input has differed from it for
// DEBOUNCE_CYCLES consecutive samples; any matching sample restarts the count.
module tetris_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise,
  output logic fall
);

  localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others (sync2 must see the old sync1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tetris_input_arbiter.sv
// Button front end for the Tetris core: debounces four buttons, generates press
// and auto-repeat requests, and issues them one at a time as fixed-length one-hot
// command pulses separated by a mandatory low gap (the core runs on clk/4).
// Ports:
//   clk, rst                       system clock, asynchronous active-high reset
//   btn_{left,right,down,spin}_raw raw buttons, asynchronous, active-high
//   Btn_Left/Right/Down/Spin       registered one-hot command pulses to the core
//   busy                           arbiter not in IDLE
//   coalesce_cnt                   saturating count of requests merged into a pending one
module tetris_input_arbiter
  import tetris_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 2**22,
  parameter int REPEAT_RATE     = 2**21,
  parameter int PULSE_CYCLES    = 16,
  parameter int GAP_CYCLES      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  input  logic       btn_down_raw,
  input  logic       btn_spin_raw,
  output logic       Btn_Left,
  output logic       Btn_Right,
  output logic       Btn_Down,
  output logic       Btn_Spin,
  output logic       busy,
  output logic [7:0] coalesce_cnt
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(PMAX + 1);

  localparam logic [TW-1:0] DELAY_LD = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] RATE_LD  = TW'(REPEAT_RATE);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] fall;
  logic [NUM_BTN-1:0] rep;
  logic [NUM_BTN-1:0] set_ev;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] pending_nxt;
  logic [NUM_BTN-1:0] grant;
  logic [NUM_BTN-1:0] clr;
  logic [NUM_BTN-1:0] merged;
  logic [NUM_BTN-1:0] cmd_q;
  logic [8:0]         coal_sum;
  logic [7:0]         coal_nxt;
  logic [TW-1:0]      rpt_timer [NUM_BTN];
  logic [CW-1:0]      phase_cnt;
  arb_state_t         state;

  assign raw[BTN_SPIN]  = btn_spin_raw;
  assign raw[BTN_LEFT]  = btn_left_raw;
  assign raw[BTN_RIGHT] = btn_right_raw;
  assign raw[BTN_DOWN]  = btn_down_raw;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    tetris_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(raw[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  // Repeat timers: loaded with REPEAT_DELAY on a press, fire when they reach 1
  // and reload with REPEAT_RATE. A release clears them. Spin never loads, so
  // its timer stays at zero and is trimmed away.
  // NOTE: the timer array is a handful of flops, not a RAM, so resetting it is
  // intended and cheap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) rpt_timer[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (fall[i])                        rpt_timer[i] <= '0;
        else if (rise[i] && REPEATABLE[i])  rpt_timer[i] <= DELAY_LD;
        else if (rpt_timer[i] == TW'(1))    rpt_timer[i] <= RATE_LD;
        else if (rpt_timer[i] != '0)        rpt_timer[i] <= rpt_timer[i] - 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    rep = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      rep[i] = REPEATABLE[i] && !fall[i] && (rpt_timer[i] == TW'(1));
    end
  end

  assign set_ev = rise | rep;

  // A set and a clear on the same bit leave it set, so a fresh press landing on
  // the grant cycle is kept; only sets on a still-pending bit count as merges.
  always_comb begin
    grant       = grant_onehot(pending);
    clr         = (state == IDLE) ? grant : '0;
    merged      = set_ev & pending & ~clr;
    pending_nxt = (pending & ~clr) | set_ev;
    coal_sum    = {1'b0, coalesce_cnt} + 9'($countones(merged));
    coal_nxt    = coal_sum[8] ? 8'hFF : coal_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cmd_q        <= '0;
      phase_cnt    <= '0;
      pending      <= '0;
      coalesce_cnt <= '0;
    end else begin
      pending      <= pending_nxt;
      coalesce_cnt <= coal_nxt;
      case (state)
        IDLE: begin
          if (|pending) begin
            state     <= ISSUE;
            cmd_q     <= grant;
            phase_cnt <= PULSE_LD;
          end
        end
        ISSUE: begin
          if (phase_cnt == CW'(1)) begin
            state     <= GAP;
            cmd_q     <= '0;
            phase_cnt <= GAP_LD;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        GAP: begin
          if (phase_cnt == CW'(1)) begin
            state     <= IDLE;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_q     <= '0;
          phase_cnt <= '0;
        end
      endcase
    end
  end

  assign Btn_Spin  = cmd_q[BTN_SPIN];
  assign Btn_Left  = cmd_q[BTN_LEFT];
  assign Btn_Right = cmd_q[BTN_RIGHT];
  assign Btn_Down  = cmd_q[BTN_DOWN];
  assign busy      = (state != IDLE);

endmodule
